// File: rtl/lenet_pool_pkg.sv
// Shared definitions for the LeNet pooling stages: default geometry,
// FSM state encoding and a signed max helper.
package lenet_pool_pkg;

    localparam int POOL_DATA_W = 16;
    localparam int POOL_FM_W   = 24;
    localparam int POOL_FM_H   = 24;
    localparam int POOL_CH_NUM = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pool_state_t;

    // Signed max on 32-bit operands; callers sign-extend narrower pixels
    // into it and truncate the result back (pixel width must be <= 32).
    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        if (a >= b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer holding the horizontal maxima of the even input row.
// One synchronous write port, one combinational read port.
module pool_line_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 12,
    parameter int IDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem_r [DEPTH];

    // Storage update: clear on reset, otherwise write one slot when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[wr_idx] <= wr_data;
        end else begin
            mem_r[wr_idx] <= mem_r[wr_idx];
        end
    end

    // Combinational read of the slot under the current column pair.
    always_comb begin
        rd_data = mem_r[rd_idx];
    end

endmodule

// File: rtl/pool_1.sv
// pool_1: 2x2 / stride-2 signed max pooling over a raster stream of
// CH_NUM channels of FM_H x FM_W pixels, writing into the pool BRAM.
// Optional build macro POOL_RELU_EN: clamps negative pooled results to 0.
// FM_W must be even and at least 4; FM_H must be even.
module pool_1
    import lenet_pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int FM_W   = POOL_FM_W,
    parameter int FM_H   = POOL_FM_H,
    parameter int CH_NUM = POOL_CH_NUM,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pool_1_en,
    input  logic                     in_vld,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_rdy,
    output logic                     pool_bram_en,
    output logic                     pool_bram_we,
    output logic [ADDR_W-1:0]        pool_bram_addr,
    output logic [DATA_W-1:0]        pool_bram_din,
    output logic                     busy,
    output logic                     pool_done
);

    localparam int COL_W = $clog2(FM_W);
    localparam int ROW_W = (FM_H > 1) ? $clog2(FM_H) : 1;
    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int LB_W  = COL_W - 1;

    pool_state_t state_r, state_s;

    logic                     en_d_r;
    logic                     en_p_s;
    logic [COL_W-1:0]         col_r;
    logic [ROW_W-1:0]         row_r;
    logic [CH_W-1:0]          ch_r;
    logic [ADDR_W-1:0]        wr_addr_r;
    logic signed [DATA_W-1:0] hold_r;

    logic                     accept_s;
    logic                     last_col_s;
    logic                     last_row_s;
    logic                     last_ch_s;
    logic                     last_pix_s;
    logic                     wr_fire_s;
    logic                     lb_we_s;
    logic signed [DATA_W-1:0] hmax_s;
    logic signed [DATA_W-1:0] lb_rd_s;
    logic signed [DATA_W-1:0] pooled_s;
    logic signed [DATA_W-1:0] wr_data_s;

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (FM_W / 2),
        .IDX_W  (LB_W)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (lb_we_s),
        .wr_idx  (col_r[COL_W-1:1]),
        .wr_data (hmax_s),
        .rd_idx  (col_r[COL_W-1:1]),
        .rd_data (lb_rd_s)
    );

    // Datapath decode: start edge, accepted pixel, raster position and maxima.
    always_comb begin
        en_p_s     = pool_1_en & ~en_d_r;
        // A restart in RUN discards the pixel presented in the same cycle.
        accept_s   = (state_r == RUN) && in_vld && !en_p_s;
        last_col_s = (col_r == COL_W'(FM_W - 1));
        last_row_s = (row_r == ROW_W'(FM_H - 1));
        last_ch_s  = (ch_r == CH_W'(CH_NUM - 1));
        last_pix_s = last_col_s && last_row_s && last_ch_s;
        hmax_s     = DATA_W'(smax(32'(hold_r), 32'(in_data)));
        pooled_s   = DATA_W'(smax(32'(lb_rd_s), 32'(hmax_s)));
        lb_we_s    = accept_s && !row_r[0] && col_r[0];
        wr_fire_s  = accept_s && row_r[0] && col_r[0];
`ifdef POOL_RELU_EN
        if (pooled_s[DATA_W-1]) begin
            wr_data_s = '0;
        end else begin
            wr_data_s = pooled_s;
        end
`else
        wr_data_s = pooled_s;
`endif
    end

    // Next-state logic: start/restart, end-of-frame flush, return to idle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en_p_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (en_p_s) begin
                    state_s = RUN;
                end else if (accept_s && last_pix_s) begin
                    state_s = FLUSH;
                end else begin
                    state_s = RUN;
                end
            end
            FLUSH: begin
                if (en_p_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered copy of the enable for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            en_d_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            en_d_r  <= pool_1_en;
        end
    end

    // Raster counters, hold register and write address.
    always_ff @(posedge clk) begin
        if (rst || en_p_s) begin
            col_r     <= '0;
            row_r     <= '0;
            ch_r      <= '0;
            wr_addr_r <= '0;
            hold_r    <= '0;
        end else if (accept_s) begin
            if (!col_r[0]) begin
                hold_r <= in_data;
            end else begin
                hold_r <= hold_r;
            end
            if (wr_fire_s) begin
                wr_addr_r <= wr_addr_r + ADDR_W'(1);
            end else begin
                wr_addr_r <= wr_addr_r;
            end
            if (last_col_s) begin
                col_r <= '0;
                if (last_row_s) begin
                    row_r <= '0;
                    if (last_ch_s) begin
                        ch_r <= '0;
                    end else begin
                        ch_r <= ch_r + CH_W'(1);
                    end
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            col_r     <= col_r;
            row_r     <= row_r;
            ch_r      <= ch_r;
            wr_addr_r <= wr_addr_r;
            hold_r    <= hold_r;
        end
    end

    // Registered outputs: BRAM write one cycle after the completing pixel,
    // status flags tracking the next state, done pulse on FLUSH -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pool_bram_en   <= 1'b0;
            pool_bram_we   <= 1'b0;
            pool_bram_addr <= '0;
            pool_bram_din  <= '0;
            in_rdy         <= 1'b0;
            busy           <= 1'b0;
            pool_done      <= 1'b0;
        end else begin
            pool_bram_en <= wr_fire_s;
            pool_bram_we <= wr_fire_s;
            if (wr_fire_s) begin
                pool_bram_addr <= wr_addr_r;
                pool_bram_din  <= wr_data_s;
            end else begin
                pool_bram_addr <= pool_bram_addr;
                pool_bram_din  <= pool_bram_din;
            end
            in_rdy    <= (state_s == RUN);
            busy      <= (state_s == RUN) || (state_s == FLUSH);
            pool_done <= (state_r == FLUSH) && (state_s == IDLE);
        end
    end

endmodule

// File: doc/pool_1.md
Name: pool_1

Overview:
- 2x2/stride-2 max-pooling stage directly downstream of conv_1.
- Consumes the conv_1 feature map as a raster stream, one channel after another: FM_H rows of FM_W pixels per channel, CH_NUM channels.
- Writes the pooled (FM_H/2)x(FM_W/2)xCH_NUM map into the pool BRAM that feeds conv_2.
- Uses a one-row line buffer; no back-pressure toward the producer.

Parameters:
- DATA_W, 16, signed fixed-point pixel width
- FM_W, 24, input feature-map width (even)
- FM_H, 24, input feature-map height (even)
- CH_NUM, 6, number of channels per run
- ADDR_W, 10, pool BRAM address width; must satisfy 2^ADDR_W >= CH_NUM*FM_H*FM_W/4

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pool_1_en  in  1  level enable; rising edge starts a run
- in_vld  in  1  input pixel valid
- in_data  in  DATA_W  signed input pixel
- in_rdy  out  1  high while in RUN
- pool_bram_en  out  1  pool BRAM port enable
- pool_bram_we  out  1  pool BRAM write strobe
- pool_bram_addr  out  ADDR_W  pool BRAM write address
- pool_bram_din  out  DATA_W  pooled value
- busy  out  1  high in RUN and FLUSH
- pool_done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset is rst: synchronous, active-high; clock is clk. All outputs reset to 0; state resets to IDLE; all counters reset to 0.
- Start detection: pool_1_en_p = pool_1_en & ~pool_1_en_d, where pool_1_en_d is a registered copy of pool_1_en.
- State IDLE:
  - in_rdy=0; in_vld is ignored.
  - On pool_1_en_p: clear col, row, ch, wr_addr and the held pixel; go to RUN.
- State RUN:
  - in_rdy=1. Each cycle with in_vld=1 accepts exactly one pixel. Gaps in in_vld are allowed; state and counters hold during gaps.
  - col counts 0..FM_W-1, then wraps to 0 and row increments.
  - row counts 0..FM_H-1, then wraps to 0 and ch increments.
  - Even col: store the pixel in the hold register.
  - Odd col: hmax = signed max(hold, in_data).
  - Even row, odd col: line_buf[col>>1] <= hmax.
  - Odd row, odd col: pooled = signed max(line_buf[col>>1], hmax). One cycle later, assert pool_bram_en=pool_bram_we=1 with pool_bram_din=pooled and pool_bram_addr=wr_addr; wr_addr then increments.
  - Latency is exactly 1 cycle from the completing input to the write. At most one write per cycle.
  - Accepting the last pixel (ch=CH_NUM-1, row=FM_H-1, col=FM_W-1) moves the FSM to FLUSH.
- State FLUSH:
  - in_rdy=0. The final write occurs in this cycle.
  - Next cycle: pool_done=1 for one cycle; return to IDLE.
- pool_bram_en/we are 0 on every cycle without a write. wr_addr after a full run = CH_NUM*FM_H*FM_W/4 (864 at defaults).
- Ties: equal values give the same result regardless of operand order; compare is signed two's complement.
- pool_1_en_p while in RUN or FLUSH: restart. A pending write still completes, but pool_done is not pulsed. Counters and wr_addr clear; stay in or enter RUN.
- rst mid-run: immediate return to IDLE; no write and no pool_done that cycle.
- pool_1_en falling mid-run: no effect; the run completes.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: pool_bram_din = pooled if pooled >= 0, else 0 (ReLU fused after the max). Latency is unchanged.
- Undefined: pool_bram_din = raw signed max, including negative values.

Decomposition:
- Package lenet_pool_pkg holds:
  - DATA_W, FM_W, FM_H and CH_NUM defaults
  - state encoding IDLE=2'd0, RUN=2'd1, FLUSH=2'd2
  - a signed max function
- Sub-module pool_line_buf: FM_W/2 x DATA_W register array with one synchronous write port and one combinational read port, indexed by col>>1.

Test Plan:
- Single channel ramp (CH_NUM=1, FM_W=FM_H=4, in_data = raster index 0..15) -> 4 writes: addr0=5, addr1=7, addr2=13, addr3=15. pool_done pulses 1 cycle after the last write.
- Negative data (all -3, except pixel (1,1)=-1 in a 2x2 window) -> window output -1. With POOL_RELU_EN defined, all outputs are 0.
- in_vld toggled 1/0 every cycle over a default-size run -> same 864 values and addresses as with continuous in_vld. No write while in_vld gaps hold; wr_addr ends at 864.
- pool_1_en_p issued at pixel 100 of a run -> wr_addr resets to 0, no pool_done for the aborted run. The next full run produces addr 0..863 and a single pool_done.
- rst asserted mid-run -> next cycle all outputs are 0 and state is IDLE; in_vld is ignored until the next pool_1_en_p.
- Input 0x7FFF vs 0x8000 in the same window -> output 0x7FFF (signed compare, no unsigned misordering).
